// File: rtl/sample_window_stats.sv
// sample_window_stats: gathers 2**WIN_LOG2 accepted samples per window and
// publishes min, max, truncated mean (and optionally the largest step between
// consecutive samples) through a valid/ready result register.
// Optional feature macro: STATS_DELTA_EN (enables the res_delta datapath;
// when undefined res_delta is tied to zero).
//
// state | meaning
// EMPTY | result register holds nothing, res_valid=0
// FULL  | result register holds an unconsumed window result, res_valid=1
module sample_window_stats #(
  parameter int DATA_W   = 8,
  parameter int WIN_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              res_ready,
  input  logic              ovr_clr,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_min,
  output logic [DATA_W-1:0] res_max,
  output logic [DATA_W-1:0] res_mean,
  output logic [DATA_W-1:0] res_delta,
  output logic              overrun
);

  localparam int SUM_W = DATA_W + WIN_LOG2;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIN_LOG2-1:0] r_cnt;
  logic [DATA_W-1:0]   r_min;
  logic [DATA_W-1:0]   r_max;
  logic [SUM_W-1:0]    r_sum;
  logic [DATA_W-1:0]   r_res_min;
  logic [DATA_W-1:0]   r_res_max;
  logic [DATA_W-1:0]   r_res_mean;
  logic                r_ovr;

  logic                w_acc;
  logic                w_first;
  logic                w_done;
  logic                w_load;
  logic                w_ovr_set;
  logic [DATA_W-1:0]   w_min_nxt;
  logic [DATA_W-1:0]   w_max_nxt;
  logic [SUM_W-1:0]    w_sum_nxt;

  // Acceptance and window-position decode; the first sample never looks at stale values
  always_comb begin
    w_acc     = ena & sample_valid;
    w_first   = (r_cnt == '0);
    w_done    = w_acc & (r_cnt == {WIN_LOG2{1'b1}});
    w_min_nxt = (w_first || (sample_in < r_min)) ? sample_in : r_min;
    w_max_nxt = (w_first || (sample_in > r_max)) ? sample_in : r_max;
    w_sum_nxt = w_first ? SUM_W'(sample_in) : (r_sum + SUM_W'(sample_in));
  end

  // Running accumulators and sample counter; only accepted samples advance them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_min <= '0;
      r_max <= '0;
      r_sum <= '0;
    end else if (w_acc) begin
      r_cnt <= r_cnt + 1'b1;
      r_min <= w_min_nxt;
      r_max <= w_max_nxt;
      r_sum <= w_sum_nxt;
    end
  end

  // Result-register FSM next state plus load / overrun decisions
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ovr_set   = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_done) begin
          w_state_nxt = FULL;
          w_load      = 1'b1;
        end
      end
      FULL: begin
        if (w_done) begin
          w_load    = res_ready;
          w_ovr_set = ~res_ready;
        end else if (res_ready) begin
          w_state_nxt = EMPTY;
        end
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Result registers capture the window including its completing sample
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res_min  <= '0;
      r_res_max  <= '0;
      r_res_mean <= '0;
    end else if (w_load) begin
      r_res_min  <= w_min_nxt;
      r_res_max  <= w_max_nxt;
      r_res_mean <= w_sum_nxt[SUM_W-1:WIN_LOG2];
    end
  end

  // Sticky overrun; a new discard in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (!rst_n)         r_ovr <= 1'b0;
    else if (w_ovr_set) r_ovr <= 1'b1;
    else if (ovr_clr)   r_ovr <= 1'b0;
  end

`ifdef STATS_DELTA_EN
  logic [DATA_W-1:0] r_prev;
  logic [DATA_W-1:0] r_delta;
  logic [DATA_W-1:0] r_res_delta;
  logic [DATA_W-1:0] w_diff;
  logic [DATA_W-1:0] w_delta_nxt;

  // Unsigned step size against the previous sample of this window
  always_comb begin
    w_diff      = (sample_in >= r_prev) ? (sample_in - r_prev) : (r_prev - sample_in);
    w_delta_nxt = w_first ? '0 : ((w_diff > r_delta) ? w_diff : r_delta);
  end

  // Previous-sample and running/result delta registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev      <= '0;
      r_delta     <= '0;
      r_res_delta <= '0;
    end else begin
      if (w_acc) begin
        r_prev  <= sample_in;
        r_delta <= w_delta_nxt;
      end
      if (w_load) r_res_delta <= w_delta_nxt;
    end
  end

  assign res_delta = r_res_delta;
`else
  assign res_delta = '0;
`endif

  assign res_valid = (r_state == FULL);
  assign res_min   = r_res_min;
  assign res_max   = r_res_max;
  assign res_mean  = r_res_mean;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_sample_window_stats.sv
// Testbench for sample_window_stats (WIN_LOG2=2): directed scenarios with
// fixed expected numbers plus randomized traffic against a queue-based model.
module tb_sample_window_stats;

  localparam int DW = 8;
  localparam int WL = 2;
  localparam int WN = 1 << WL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          res_ready = 1'b0;
  logic          ovr_clr = 1'b0;
  logic          res_valid;
  logic [DW-1:0] res_min, res_max, res_mean, res_delta;
  logic          overrun;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural reference state
  int          q[$];
  logic        m_valid = 0;
  logic [7:0]  m_min = 0, m_max = 0, m_mean = 0, m_delta = 0;
  logic        m_ovr = 0;

  sample_window_stats #(.DATA_W(DW), .WIN_LOG2(WL)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sample_in(sample_in),
    .sample_valid(sample_valid), .res_ready(res_ready), .ovr_clr(ovr_clr),
    .res_valid(res_valid), .res_min(res_min), .res_max(res_max),
    .res_mean(res_mean), .res_delta(res_delta), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, let the edge happen, update the model, settle.
  task automatic tick(input bit rst, input bit en, input bit sv, input int s,
                      input bit rdy, input bit clr);
    bit done;
    int sum, mn, mx, dl, d;
    rst_n = rst; ena = en; sample_valid = sv; sample_in = s[7:0];
    res_ready = rdy; ovr_clr = clr;
    @(posedge clk);
    done = 0;
    if (!rst) begin
      q.delete();
      m_valid = 0; m_min = 0; m_max = 0; m_mean = 0; m_delta = 0; m_ovr = 0;
    end else begin
      if (en && sv) begin
        q.push_back(s & 255);
        if (q.size() == WN) begin
          done = 1;
          sum = 0; mn = 255; mx = 0; dl = 0;
          foreach (q[i]) begin
            sum += q[i];
            if (q[i] < mn) mn = q[i];
            if (q[i] > mx) mx = q[i];
            if (i > 0) begin
              d = (q[i] > q[i-1]) ? q[i] - q[i-1] : q[i-1] - q[i];
              if (d > dl) dl = d;
            end
          end
          q.delete();
        end
      end
      if (done && m_valid && !rdy) m_ovr = 1;
      else if (clr) m_ovr = 0;
      if (done && (!m_valid || rdy)) begin
        m_valid = 1;
        m_min = mn[7:0]; m_max = mx[7:0]; m_mean = 8'((sum / WN) & 255);
`ifdef STATS_DELTA_EN
        m_delta = dl[7:0];
`else
        m_delta = 0;
`endif
      end else if (!done && m_valid && rdy) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, 1, 77, 1, 0);
    n_total++;
    if ({res_valid, res_min, res_max, res_mean, res_delta, overrun} !== 34'd0)
      $display("FAIL reset: got v=%0b min=%0d max=%0d mean=%0d dl=%0d ovr=%0b, expected all 0",
               res_valid, res_min, res_max, res_mean, res_delta, overrun);
    else n_pass++;
  endtask

  task automatic test_basic();
    int s[4] = '{10, 20, 30, 40};
    int exp_dl;
`ifdef STATS_DELTA_EN
    exp_dl = 10;
`else
    exp_dl = 0;
`endif
    for (int i = 0; i < 4; i++) tick(1, 1, 1, s[i], 1, 0);
    n_total++;
    if ({res_valid, res_min, res_max, res_mean, res_delta} !== {1'b1, 8'd10, 8'd40, 8'd25, 8'(exp_dl)})
      $display("FAIL basic: got v=%0b min=%0d max=%0d mean=%0d dl=%0d, expected 1/10/40/25/%0d",
               res_valid, res_min, res_max, res_mean, res_delta, exp_dl);
    else n_pass++;
    tick(1, 1, 0, 0, 1, 0);
    n_total++;
    if (res_valid !== 1'b0) $display("FAIL basic_consume: got v=%0b, expected 0", res_valid);
    else n_pass++;
  endtask

  task automatic test_gaps();
    int s[4] = '{10, 20, 30, 40};
    for (int i = 0; i < 4; i++) begin
      int g = $urandom_range(0, 3);
      for (int k = 0; k < g; k++) begin
        if ($urandom_range(0, 1) == 1) tick(1, 0, 1, 99, 1, 0);
        else                           tick(1, 1, 0, 99, 1, 0);
      end
      tick(1, 1, 1, s[i], 1, 0);
      if (i < 3) begin
        n_total++;
        if (res_valid !== 1'b0) $display("FAIL gaps_early: got v=%0b after %0d samples, expected 0", res_valid, i + 1);
        else n_pass++;
      end
    end
    n_total++;
    if ({res_valid, res_min, res_max, res_mean, res_delta} !== {1'b1, m_min, m_max, m_mean, m_delta}
        || res_mean !== 8'd25)
      $display("FAIL gaps: got v=%0b min=%0d max=%0d mean=%0d dl=%0d, expected 1/10/40/25/%0d",
               res_valid, res_min, res_max, res_mean, res_delta, m_delta);
    else n_pass++;
    tick(1, 1, 0, 0, 1, 0);
  endtask

  task automatic test_extremes();
    int s[8] = '{255, 255, 255, 255, 0, 255, 0, 255};
    int dl2;
`ifdef STATS_DELTA_EN
    dl2 = 255;
`else
    dl2 = 0;
`endif
    for (int i = 0; i < 4; i++) tick(1, 1, 1, s[i], 1, 0);
    n_total++;
    if ({res_valid, res_min, res_max, res_mean, res_delta} !== {1'b1, 8'd255, 8'd255, 8'd255, 8'd0})
      $display("FAIL all255: got v=%0b min=%0d max=%0d mean=%0d dl=%0d, expected 1/255/255/255/0",
               res_valid, res_min, res_max, res_mean, res_delta);
    else n_pass++;
    for (int i = 4; i < 8; i++) tick(1, 1, 1, s[i], 1, 0);
    n_total++;
    if ({res_valid, res_min, res_max, res_mean, res_delta} !== {1'b1, 8'd0, 8'd255, 8'd127, 8'(dl2)})
      $display("FAIL alt0_255: got v=%0b min=%0d max=%0d mean=%0d dl=%0d, expected 1/0/255/127/%0d",
               res_valid, res_min, res_max, res_mean, res_delta, dl2);
    else n_pass++;
    tick(1, 1, 0, 0, 1, 0);
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 8; i++) tick(1, 1, 1, i, 0, 0);
    n_total++;
    if ({res_valid, res_min, res_max, res_mean, overrun} !== {1'b1, 8'd1, 8'd4, 8'd2, 1'b1})
      $display("FAIL overrun_hold: got v=%0b min=%0d max=%0d mean=%0d ovr=%0b, expected 1/1/4/2/1",
               res_valid, res_min, res_max, res_mean, overrun);
    else n_pass++;
    tick(1, 1, 0, 0, 0, 1);
    n_total++;
    if ({overrun, res_valid, res_min} !== {1'b0, 1'b1, 8'd1})
      $display("FAIL ovr_clr: got ovr=%0b v=%0b min=%0d, expected 0/1/1", overrun, res_valid, res_min);
    else n_pass++;
    tick(1, 1, 0, 0, 1, 0);
    n_total++;
    if (res_valid !== 1'b0) $display("FAIL overrun_drain: got v=%0b, expected 0", res_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 7; i++) tick(1, 1, 1, i, 0, 0);
    tick(1, 1, 1, 8, 1, 0);
    n_total++;
    if ({res_valid, res_min, res_max, res_mean, overrun} !== {1'b1, 8'd5, 8'd8, 8'd6, 1'b0})
      $display("FAIL back_to_back: got v=%0b min=%0d max=%0d mean=%0d ovr=%0b, expected 1/5/8/6/0",
               res_valid, res_min, res_max, res_mean, overrun);
    else n_pass++;
    tick(1, 1, 0, 0, 1, 0);
  endtask

  task automatic test_mid_reset();
    tick(1, 1, 1, 200, 1, 0);
    tick(1, 1, 1, 1, 1, 0);
    tick(0, 1, 0, 0, 1, 0);
    n_total++;
    if ({res_valid, res_min, res_max, res_mean, res_delta, overrun} !== 34'd0)
      $display("FAIL mid_reset: got v=%0b min=%0d max=%0d mean=%0d, expected all 0",
               res_valid, res_min, res_max, res_mean);
    else n_pass++;
    for (int i = 5; i <= 8; i++) tick(1, 1, 1, i, 1, 0);
    n_total++;
    if ({res_valid, res_min, res_max, res_mean} !== {1'b1, 8'd5, 8'd8, 8'd6})
      $display("FAIL post_reset: got v=%0b min=%0d max=%0d mean=%0d, expected 1/5/8/6",
               res_valid, res_min, res_max, res_mean);
    else n_pass++;
    tick(1, 1, 0, 0, 1, 0);
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 400; c++) begin
      tick(1, ($urandom % 5) != 0, ($urandom % 4) != 0, $urandom_range(0, 255),
           ($urandom % 2) == 1, ($urandom % 8) == 0);
      n_total++;
      if ({res_valid, res_min, res_max, res_mean, res_delta, overrun} !==
          {m_valid, m_min, m_max, m_mean, m_delta, m_ovr}) begin
        if (errs < 10)
          $display("FAIL random[%0d]: got v=%0b min=%0d max=%0d mean=%0d dl=%0d ovr=%0b, expected v=%0b min=%0d max=%0d mean=%0d dl=%0d ovr=%0b",
                   c, res_valid, res_min, res_max, res_mean, res_delta, overrun,
                   m_valid, m_min, m_max, m_mean, m_delta, m_ovr);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_extremes();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
